controle_pilha_retorno: RTL and testbench

- Master side of the return-stack interface for the Forth core.
- Accepts call/return and return-stack word requests from the instruction decoder (CALL, EXIT, >R, R>, R@).
- Converts each request into single-cycle push/pop strobes toward the return-stack RAM block.
- Tracks stack depth locally, waits out the stack's read latency, and returns popped or fetched values (return PC or data) to the core with overflow/underflow error flags.

---
 rtl/controle_pilha_retorno_if.sv | 31 +++
 rtl/controle_pilha_retorno.sv | 151 +++++++++++++++
 tb/tb_controle_pilha_retorno.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controle_pilha_retorno_if.sv
// Request/response and return-stack strobe bundle between the Forth decoder, the controller and the stack RAM.
// The master modport is the controller's view; the slave modport is the decoder/RAM side.
interface controle_pilha_retorno_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic [2:0]            req_op;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  req_ready;

    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_err;

    logic                  rs_push;
    logic                  rs_pop;
    logic [DATA_WIDTH-1:0] rs_wdata;
    logic [DATA_WIDTH-1:0] rs_q;

    modport master (
        input  req_valid, req_op, req_data, rs_q,
        output req_ready, resp_valid, resp_data, resp_err,
        output rs_push, rs_pop, rs_wdata
    );

    modport slave (
        output req_valid, req_op, req_data, rs_q,
        input  req_ready, resp_valid, resp_data, resp_err,
        input  rs_push, rs_pop, rs_wdata
    );
endinterface

// File: rtl/controle_pilha_retorno.sv
// Return-stack controller: turns CALL/EXIT/>R/R>/R@ into push/pop strobes and returns values with error flags.
// Latency 1 cycle for pushes, 2-4 for reads (waits out stack read latency); one request in flight, req_ready only in IDLE.
module controle_pilha_retorno #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset_n,
    controle_pilha_retorno_if.master bus,
    output logic [ADDR_WIDTH:0]      depth,
    output logic                     overflow,
    output logic                     underflow
);
    localparam logic [2:0] OP_CALL   = 3'd0;
    localparam logic [2:0] OP_EXIT   = 3'd1;
    localparam logic [2:0] OP_TOR    = 3'd2;
    localparam logic [2:0] OP_FROMR  = 3'd3;
    localparam logic [2:0] OP_RFETCH = 3'd4;

    localparam int                  CAPACITY   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_FULL = CAPACITY[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] DEPTH_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            settle;
    logic                  pop_pending;
    logic                  resp_valid_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic                  resp_err_q;
    logic                  rs_push_q;
    logic                  rs_pop_q;
    logic [DATA_WIDTH-1:0] rs_wdata_q;

    logic is_push;
    logic is_read;
    logic is_pop;

    always_comb begin
        is_push = (bus.req_op == OP_CALL) || (bus.req_op == OP_TOR);
        is_pop  = (bus.req_op == OP_EXIT) || (bus.req_op == OP_FROMR);
        is_read = is_pop || (bus.req_op == OP_RFETCH);
    end

    assign bus.req_ready  = (state == ST_IDLE) & reset_n;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.rs_push    = rs_push_q;
    assign bus.rs_pop     = rs_pop_q;
    assign bus.rs_wdata   = rs_wdata_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            depth        <= '0;
            settle       <= 2'd0;
            pop_pending  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            rs_push_q    <= 1'b0;
            rs_pop_q     <= 1'b0;
            rs_wdata_q   <= '0;
        end else begin
            rs_push_q <= 1'b0;
            rs_pop_q  <= 1'b0;

            // rs_q only reflects a strobe two cycles after the strobe itself
            if (rs_push_q || rs_pop_q) begin
                settle <= 2'd2;
            end else if (settle != 2'd0) begin
                settle <= settle - 2'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        resp_data_q <= '0;
                        pop_pending <= is_pop;
                        if (is_push) begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            if (depth == DEPTH_FULL) begin
                                resp_err_q <= 1'b1;
                                overflow   <= 1'b1;
                            end else begin
                                resp_err_q <= 1'b0;
                                rs_push_q  <= 1'b1;
                                rs_wdata_q <= bus.req_data;
                                depth      <= depth + DEPTH_ONE;
                            end
                        end else if (is_read) begin
                            if (depth == '0) begin
                                state        <= ST_RESP;
                                resp_valid_q <= 1'b1;
                                resp_err_q   <= 1'b1;
                                underflow    <= 1'b1;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end else begin
                            state        <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end
                    end
                end

                ST_WAIT: begin
                    if (settle == 2'd0) begin
                        resp_data_q  <= bus.rs_q;
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= ST_RESP;
                        if (pop_pending) begin
                            rs_pop_q <= 1'b1;
                            depth    <= depth - DEPTH_ONE;
                        end
                    end
                end

                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_data_q  <= '0;
                    state        <= ST_IDLE;
                end

                default: begin
                    state        <= ST_IDLE;
                    resp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    a_no_push_and_pop: assert property (@(posedge clock) disable iff (!reset_n)
        !(rs_push_q && rs_pop_q));
    a_depth_bounded: assert property (@(posedge clock) disable iff (!reset_n)
        depth <= DEPTH_FULL);
    a_resp_in_resp_state: assert property (@(posedge clock) disable iff (!reset_n)
        resp_valid_q == (state == ST_RESP));
endmodule

// File: tb/tb_controle_pilha_retorno.sv
// Directed bench for controle_pilha_retorno with a behavioural return-stack RAM (2-cycle read latency).
module tb_controle_pilha_retorno;
    localparam int DW = 16;
    localparam int AW = 10;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    controle_pilha_retorno_if #(.DATA_WIDTH(DW)) bus();
    logic [AW:0] depth;
    logic        overflow;
    logic        underflow;

    controle_pilha_retorno #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Stack RAM model: top visible on rs_q two cycles after the strobe edge
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [AW:0]   sp = '0;
    logic [AW:0]   top_idx;
    logic [DW-1:0] top;
    logic [DW-1:0] q1 = '0;

    always_comb begin
        top_idx = sp - 1'b1;
        top     = (sp == '0) ? '0 : mem[top_idx[AW-1:0]];
    end

    always @(posedge clock) begin
        if (!reset_n) begin
            sp <= '0;
        end else if (bus.rs_push) begin
            mem[sp[AW-1:0]] <= bus.rs_wdata;
            sp <= sp + 1'b1;
        end else if (bus.rs_pop) begin
            sp <= sp - 1'b1;
        end
        q1       <= top;
        bus.rs_q <= q1;
    end

    int pushes = 0;
    int pops = 0;
    int resps = 0;
    int both = 0;
    logic [DW-1:0] last_wdata = '0;

    always @(posedge clock) begin
        if (bus.rs_push) begin
            pushes     <= pushes + 1;
            last_wdata <= bus.rs_wdata;
        end
        if (bus.rs_pop) pops <= pops + 1;
        if (bus.resp_valid) resps <= resps + 1;
        if (bus.rs_push && bus.rs_pop) both <= both + 1;
    end

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Called at a negedge; returns at the negedge where resp_valid is seen
    task automatic do_req(input logic [2:0] op, input logic [DW-1:0] d,
                          output logic [DW-1:0] rd, output logic re, output int lat);
        int  n;
        bit  got;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.req_ready) check("ready_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_data  = d;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        rd  = '0;
        re  = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            lat++;
            if (bus.resp_valid) begin
                got = 1'b1;
                rd  = bus.resp_data;
                re  = bus.resp_err;
            end
        end
        if (!got) check("resp_timeout", 32'd0, 32'd1);
    endtask

    logic [DW-1:0] rd;
    logic          re;
    int            lat;
    int            p0, q0, r0, errs;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_data  = '0;
        reset_n       = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_depth", depth, 0);
        check("rst_push", bus.rs_push, 0);
        reset_n = 1'b1;
        #1 check("ready_after_rst", bus.req_ready, 1);

        // CALL then EXIT
        p0 = pushes;
        do_req(3'd0, 16'h0123, rd, re, lat);
        check("call_lat", lat, 1);
        check("call_err", re, 0);
        @(negedge clock);
        check("call_push_cnt", pushes - p0, 1);
        check("call_wdata", last_wdata, 16'h0123);
        check("call_depth", depth, 1);

        q0 = pops;
        do_req(3'd1, 16'h0000, rd, re, lat);
        check("exit_data", rd, 16'h0123);
        check("exit_lat", lat, 3);
        check("exit_err", re, 0);
        @(negedge clock);
        check("exit_pop_cnt", pops - q0, 1);
        check("exit_depth", depth, 0);

        // >R >R R@ R> R>
        do_req(3'd2, 16'hAAAA, rd, re, lat);
        @(negedge clock);
        do_req(3'd2, 16'h5555, rd, re, lat);
        @(negedge clock);
        q0 = pops;
        do_req(3'd4, 16'h0000, rd, re, lat);
        check("rfetch_data", rd, 16'h5555);
        check("rfetch_lat", lat, 3);
        @(negedge clock);
        check("rfetch_depth", depth, 2);
        check("rfetch_no_pop", pops - q0, 0);
        do_req(3'd3, 16'h0000, rd, re, lat);
        check("fromr1_data", rd, 16'h5555);
        check("fromr1_lat", lat, 2);
        @(negedge clock);
        check("fromr1_depth", depth, 1);
        do_req(3'd3, 16'h0000, rd, re, lat);
        check("fromr2_data", rd, 16'hAAAA);
        check("fromr2_lat", lat, 3);
        check("fromr2_err", re, 0);
        @(negedge clock);
        check("fromr2_depth", depth, 0);

        // Underflow, then illegal op
        q0 = pops;
        do_req(3'd1, 16'h0000, rd, re, lat);
        check("uf_err", re, 1);
        check("uf_data", rd, 0);
        check("uf_lat", lat, 1);
        @(negedge clock);
        check("uf_flag", underflow, 1);
        check("uf_no_pop", pops - q0, 0);
        check("uf_depth", depth, 0);
        do_req(3'd5, 16'h1111, rd, re, lat);
        check("illegal_err", re, 1);
        check("illegal_data", rd, 0);
        @(negedge clock);
        check("illegal_uf_kept", underflow, 1);
        check("illegal_no_of", overflow, 0);

        // Fill to capacity, then overflow
        p0 = pushes;
        errs = 0;
        for (int i = 0; i < (1 << AW); i++) begin
            do_req((i % 2 == 1) ? 3'd2 : 3'd0, 16'(i) ^ 16'h3C00, rd, re, lat);
            errs += int'(re);
            @(negedge clock);
        end
        check("fill_errs", errs, 0);
        check("fill_pushes", pushes - p0, 1024);
        check("fill_depth", depth, 1024);
        do_req(3'd4, 16'h0000, rd, re, lat);
        check("full_rfetch", rd, 16'h3FFF);
        @(negedge clock);
        p0 = pushes;
        do_req(3'd0, 16'hDEAD, rd, re, lat);
        check("of_err", re, 1);
        check("of_lat", lat, 1);
        @(negedge clock);
        check("of_flag", overflow, 1);
        check("of_no_push", pushes - p0, 0);
        check("of_depth", depth, 1024);

        // Reset clears sticky flags and depth
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check("rst2_depth", depth, 0);
        check("rst2_of", overflow, 0);
        check("rst2_uf", underflow, 0);

        // Reset while an EXIT waits for the stack
        do_req(3'd0, 16'hBEEF, rd, re, lat);
        @(negedge clock);
        bus.req_valid = 1'b1;
        bus.req_op    = 3'd1;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        q0 = pops;
        r0 = resps;
        @(negedge clock);
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1 check("abort_ready", bus.req_ready, 1);
        check("abort_depth", depth, 0);
        check("abort_flags", {overflow, underflow}, 0);
        repeat (6) @(negedge clock);
        check("abort_no_pop", pops - q0, 0);
        check("abort_no_resp", resps - r0, 0);

        // Recovery after abort
        do_req(3'd0, 16'h1234, rd, re, lat);
        @(negedge clock);
        do_req(3'd1, 16'h0000, rd, re, lat);
        check("recover_data", rd, 16'h1234);
        @(negedge clock);
        check("recover_depth", depth, 0);
        check("push_pop_overlap", both, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
